// File: rtl/eeprom_rw_scheduler.sv
// eeprom_rw_scheduler: round-robin sharing of one 3-byte EEPROM engine with boot auto-load and watchdog
module eeprom_rw_scheduler #(
  parameter int         NUM_REQ     = 2,
  parameter logic [7:0] BOOT_ADDR   = 8'h00,
  parameter int         TIMEOUT_CYC = 2_000_000
) (
  input  logic                  sclk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_is_write,
  input  logic [8*NUM_REQ-1:0]  req_addr,
  input  logic [24*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [NUM_REQ-1:0]    rsp_done,
  output logic                  rsp_err,
  output logic [23:0]           rsp_rdata,
  output logic [23:0]           boot_data,
  output logic                  boot_valid,
  output logic                  busy,
  output logic [7:0]            ee_start_addr,
  output logic [23:0]           ee_wdata,
  output logic                  ee_write_trig,
  output logic                  ee_read_trig,
  input  logic                  ee_write_done,
  input  logic                  ee_read_done,
  input  logic [23:0]           ee_rdata
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT_CYC) + 1;
  typedef enum logic [2:0] {BOOT_ISSUE, BOOT_WAIT, IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, gnt, idx;
  logic [WW-1:0] wd_q, wd_d;
  logic dir_q, dir_d, any, done_m, wd_hit, g_wr;
  logic [7:0] g_addr, ee_start_addr_d;
  logic [23:0] g_wdata, ee_wdata_d, rsp_rdata_d, boot_data_d;
  logic [NUM_REQ-1:0] req_ack_d, rsp_done_d;
  logic rsp_err_d, boot_valid_d, ee_write_trig_d, ee_read_trig_d;
  assign busy   = state_q != IDLE;
  assign wd_hit = wd_q == WW'(TIMEOUT_CYC - 1);
  assign done_m = state_q == BOOT_WAIT ? ee_read_done : (dir_q ? ee_write_done : ee_read_done);
  // round-robin search starting just after the last winner, plus the winner's request fields
  always_comb begin
    any = 1'b0;
    gnt = ptr_q;
    idx = '0;
    g_addr = '0;
    g_wdata = '0;
    g_wr = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        gnt = idx;
      end
    end
    for (int j = 0; j < NUM_REQ; j++)
      if (gnt == PW'(j)) begin
        g_addr = req_addr[8*j +: 8];
        g_wdata = req_wdata[24*j +: 24];
        g_wr = req_is_write[j];
      end
  end
  // state and all registered outputs; reset aborts everything and restarts the boot load
  always_ff @(posedge sclk or posedge rst)
    if (rst) begin
      state_q <= BOOT_ISSUE;
      ptr_q <= PW'(NUM_REQ - 1);
      wd_q <= '0;
      dir_q <= 1'b0;
      req_ack <= '0;
      rsp_done <= '0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
      boot_data <= '0;
      boot_valid <= 1'b0;
      ee_start_addr <= '0;
      ee_wdata <= '0;
      ee_write_trig <= 1'b0;
      ee_read_trig <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      wd_q <= wd_d;
      dir_q <= dir_d;
      req_ack <= req_ack_d;
      rsp_done <= rsp_done_d;
      rsp_err <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      boot_data <= boot_data_d;
      boot_valid <= boot_valid_d;
      ee_start_addr <= ee_start_addr_d;
      ee_wdata <= ee_wdata_d;
      ee_write_trig <= ee_write_trig_d;
      ee_read_trig <= ee_read_trig_d;
    end
  // next state: a done or the watchdog ends each wait; a done in the same cycle wins
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT_ISSUE: state_d = BOOT_WAIT;
      BOOT_WAIT:  state_d = done_m || wd_hit ? IDLE : BOOT_WAIT;
      IDLE:       state_d = any ? ISSUE : IDLE;
      ISSUE:      state_d = WAIT;
      WAIT:       state_d = done_m || wd_hit ? IDLE : WAIT;
      default:    state_d = BOOT_ISSUE;
    endcase
  end
  // outputs and datapath: pulses default low, everything else holds
  always_comb begin
    ptr_d = ptr_q;
    dir_d = dir_q;
    wd_d = wd_q;
    req_ack_d = '0;
    rsp_done_d = '0;
    rsp_err_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    boot_data_d = boot_data;
    boot_valid_d = boot_valid;
    ee_start_addr_d = ee_start_addr;
    ee_wdata_d = ee_wdata;
    ee_write_trig_d = 1'b0;
    ee_read_trig_d = 1'b0;
    case (state_q)
      BOOT_ISSUE: begin
        ee_start_addr_d = BOOT_ADDR;
        ee_read_trig_d = 1'b1;
        wd_d = '0;
      end
      BOOT_WAIT: begin
        wd_d = wd_q + WW'(1);
        boot_data_d = done_m ? ee_rdata : boot_data;
        boot_valid_d = boot_valid | done_m;
      end
      IDLE: if (any) begin
        req_ack_d[gnt] = 1'b1;
        ptr_d = gnt;
        dir_d = g_wr;
        ee_start_addr_d = g_addr;
        ee_wdata_d = g_wdata;
      end
      ISSUE: begin
        ee_write_trig_d = dir_q;
        ee_read_trig_d = !dir_q;
        wd_d = '0;
      end
      WAIT: begin
        wd_d = wd_q + WW'(1);
        rsp_done_d[ptr_q] = done_m | wd_hit;
        rsp_err_d = !done_m && wd_hit;
        rsp_rdata_d = done_m && !dir_q ? ee_rdata : rsp_rdata;
      end
      default: ;
    endcase
  end
endmodule
